// File: rtl/rv_muldiv_pkg.sv
// rv_muldiv_pkg: shared definitions for the iterative M-extension unit.
// funct3 encodings, FSM state type, captured-operation bundle, decode helpers.
package rv_muldiv_pkg;

    localparam logic [2:0] FUNC_MUL    = 3'd0;
    localparam logic [2:0] FUNC_MULH   = 3'd1;
    localparam logic [2:0] FUNC_MULHSU = 3'd2;
    localparam logic [2:0] FUNC_MULHU  = 3'd3;
    localparam logic [2:0] FUNC_DIV    = 3'd4;
    localparam logic [2:0] FUNC_DIVU   = 3'd5;
    localparam logic [2:0] FUNC_REM    = 3'd6;
    localparam logic [2:0] FUNC_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // Operation context kept while the core iterates.
    typedef struct packed {
        logic [2:0] fun;
        logic       neg_res;
        logic       rem_neg;
    } md_op_t;

    function automatic logic rs1_signed(input logic [2:0] fun);
        return (fun == FUNC_MULH) || (fun == FUNC_MULHSU) ||
               (fun == FUNC_DIV)  || (fun == FUNC_REM);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] fun);
        return (fun == FUNC_MULH) || (fun == FUNC_DIV) ||
               (fun == FUNC_REM);
    endfunction

endpackage

// File: rtl/rv_muldiv_core.sv
// rv_muldiv_core: unsigned shift-add multiplier / restoring divider datapath.
// Ports: i_clk, i_rst (sync, high), i_clr (abort), i_start, i_is_div,
//        i_a_mag/i_b_mag (operand magnitudes); o_last (final step this
//        cycle), o_prod/o_quo/o_rem (values after the current step).
module rv_muldiv_core
    import rv_muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_UNROLL = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_start,
    input  logic              i_is_div,
    input  logic [XLEN-1:0]   i_a_mag,
    input  logic [XLEN-1:0]   i_b_mag,
    output logic              o_last,
    output logic [2*XLEN-1:0] o_prod,
    output logic [XLEN-1:0]   o_quo,
    output logic [XLEN-1:0]   o_rem
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(XLEN / MUL_UNROLL);
    localparam logic [CW-1:0] DIV_CNT = CW'(XLEN);

    logic [CW-1:0]     r_cnt;
    logic              r_is_div;
    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN:0]     r_rem;
    logic [XLEN-1:0]   r_dvsr;

    logic [2*XLEN-1:0] w_acc_nxt;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic              w_ge;
    logic [XLEN:0]     w_rem_nxt;
    logic [XLEN-1:0]   w_quo_nxt;
    logic              w_unused;

    // Retire MUL_UNROLL multiplier bits into the accumulator.
    always_comb begin
        w_acc_nxt = r_acc;
        for (int j = 0; j < MUL_UNROLL; j++) begin
            if (r_mplier[j]) begin
                w_acc_nxt = w_acc_nxt + (r_mcand << j);
            end
        end
    end

    // Restoring step: r_quo shifts dividend bits out, quotient bits in.
    assign w_shift   = {r_rem[XLEN-1:0], r_quo[XLEN-1]};
    assign w_ge      = (w_shift >= {1'b0, r_dvsr});
    assign w_diff    = w_shift - {1'b0, r_dvsr};
    assign w_rem_nxt = w_ge ? w_diff : w_shift;
    assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvsr   <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt    <= i_is_div ? DIV_CNT : MUL_CNT;
            r_is_div <= i_is_div;
            r_acc    <= '0;
            r_mcand  <= {{XLEN{1'b0}}, i_a_mag};
            r_mplier <= i_b_mag;
            r_quo    <= i_a_mag;
            r_rem    <= '0;
            r_dvsr   <= i_b_mag;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_is_div) begin
                r_quo <= w_quo_nxt;
                r_rem <= w_rem_nxt;
            end else begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << MUL_UNROLL;
                r_mplier <= r_mplier >> MUL_UNROLL;
            end
        end
    end

    // Remainder never exceeds the divisor, so its top bit stays clear.
    assign w_unused = ^{r_rem[XLEN], w_rem_nxt[XLEN]};

    assign o_last = (r_cnt == CW'(1));
    assign o_prod = w_acc_nxt;
    assign o_quo  = w_quo_nxt;
    assign o_rem  = w_rem_nxt[XLEN-1:0];

endmodule

// File: rtl/rv_muldiv.sv
// rv_muldiv: iterative RV M-extension unit with stall/hold handshake.
// Ports: clk_i, rst_i, d_valid_i, d_is_muldiv_i, d_fun_i, rs1_i, rs2_i,
//        x_stall_i, x_kill_i; stall_req_o, result_o, result_valid_o.
module rv_muldiv
    import rv_muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_UNROLL = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            d_valid_i,
    input  logic            d_is_muldiv_i,
    input  logic [2:0]      d_fun_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            x_stall_i,
    input  logic            x_kill_i,
    output logic            stall_req_o,
    output logic [XLEN-1:0] result_o,
    output logic            result_valid_o
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t       r_state;
    md_state_t       w_state_nxt;
    md_op_t          r_op;
    logic [XLEN-1:0] r_result;

    logic              w_req;
    logic              w_idle;
    logic              w_busy;
    logic              w_is_div;
    logic              w_is_rem;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic              w_start;
    logic              w_load_special;
    logic              w_load_final;
    logic              w_core_last;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo_s;
    logic [XLEN-1:0]   w_rem_s;
    logic [XLEN-1:0]   w_final_res;

    assign w_req  = d_valid_i & d_is_muldiv_i & ~x_kill_i;
    assign w_idle = (r_state == MD_IDLE);
    assign w_busy = (r_state == MD_BUSY);

    assign w_is_div = d_fun_i[2];
    assign w_is_rem = d_fun_i[1];
    assign w_a_neg  = rs1_signed(d_fun_i) & rs1_i[XLEN-1];
    assign w_b_neg  = rs2_signed(d_fun_i) & rs2_i[XLEN-1];
    assign w_a_mag  = w_a_neg ? (~rs1_i + 1'b1) : rs1_i;
    assign w_b_mag  = w_b_neg ? (~rs2_i + 1'b1) : rs2_i;

    // Divide-by-zero and INT_MIN / -1 bypass the iterative core.
    assign w_div0 = w_is_div & (rs2_i == '0);
    assign w_ovf  = w_is_div & ~d_fun_i[0] &
                    (rs1_i == INT_MIN) & (rs2_i == '1);
    assign w_special = w_div0 | w_ovf;

    always_comb begin
        w_special_res = '0;
        unique case (1'b1)
            w_div0:  w_special_res = w_is_rem ? rs1_i : '1;
            w_ovf:   w_special_res = w_is_rem ? '0 : rs1_i;
            default: w_special_res = '0;
        endcase
    end

    assign w_start        = w_idle & w_req & ~w_special;
    assign w_load_special = w_idle & w_req & w_special;
    assign w_load_final   = w_busy & w_core_last & ~x_kill_i;

    rv_muldiv_core #(
        .XLEN       (XLEN),
        .MUL_UNROLL (MUL_UNROLL)
    ) u_core (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_clr    (x_kill_i),
        .i_start  (w_start),
        .i_is_div (w_is_div),
        .i_a_mag  (w_a_mag),
        .i_b_mag  (w_b_mag),
        .o_last   (w_core_last),
        .o_prod   (w_prod),
        .o_quo    (w_quo),
        .o_rem    (w_rem)
    );

    // Two's-complement fixup of the unsigned core results.
    assign w_prod_s = r_op.neg_res ? (~w_prod + 1'b1) : w_prod;
    assign w_quo_s  = r_op.neg_res ? (~w_quo + 1'b1) : w_quo;
    assign w_rem_s  = r_op.rem_neg ? (~w_rem + 1'b1) : w_rem;

    always_comb begin
        w_final_res = '0;
        if (r_op.fun[2]) begin
            w_final_res = r_op.fun[1] ? w_rem_s : w_quo_s;
        end else if (r_op.fun == FUNC_MUL) begin
            w_final_res = w_prod_s[XLEN-1:0];
        end else begin
            w_final_res = w_prod_s[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            MD_IDLE: begin
                if (w_req) begin
                    w_state_nxt = w_special ? MD_DONE : MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (w_core_last) begin
                    w_state_nxt = MD_DONE;
                end
            end
            MD_DONE: begin
                if (!x_stall_i) begin
                    w_state_nxt = MD_IDLE;
                end
            end
            default: w_state_nxt = MD_IDLE;
        endcase
        if (x_kill_i) begin
            w_state_nxt = MD_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op <= '0;
        end else if (w_idle && w_req) begin
            r_op.fun     <= d_fun_i;
            r_op.neg_res <= w_a_neg ^ w_b_neg;
            r_op.rem_neg <= w_a_neg;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_result <= '0;
        end else if (w_load_special) begin
            r_result <= w_special_res;
        end else if (w_load_final) begin
            r_result <= w_final_res;
        end
    end

    assign stall_req_o    = ~x_kill_i & ((w_idle & w_req) | w_busy);
    assign result_o       = r_result;
    assign result_valid_o = (r_state == MD_DONE);

endmodule

// File: tb/tb_rv_muldiv.sv
// tb_rv_muldiv: vector table + scoreboard bench for rv_muldiv.
// Covers unroll 1 and 4 instances, special cases, kill, reset, hold.
module tb_rv_muldiv;
    import rv_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_valid;
    logic        u_valid;
    logic [2:0]  d_fun;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        x_stall;
    logic        x_kill;
    logic        m_stall, u_stall;
    logic [31:0] m_res, u_res;
    logic        m_rv, u_rv;

    always #5 clk = ~clk;

    rv_muldiv #(.XLEN(32), .MUL_UNROLL(1)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .d_valid_i      (d_valid),
        .d_is_muldiv_i  (1'b1),
        .d_fun_i        (d_fun),
        .rs1_i          (rs1),
        .rs2_i          (rs2),
        .x_stall_i      (x_stall),
        .x_kill_i       (x_kill),
        .stall_req_o    (m_stall),
        .result_o       (m_res),
        .result_valid_o (m_rv)
    );

    rv_muldiv #(.XLEN(32), .MUL_UNROLL(4)) dut_u4 (
        .clk_i          (clk),
        .rst_i          (rst),
        .d_valid_i      (u_valid),
        .d_is_muldiv_i  (1'b1),
        .d_fun_i        (d_fun),
        .rs1_i          (rs1),
        .rs2_i          (rs2),
        .x_stall_i      (x_stall),
        .x_kill_i       (x_kill),
        .stall_req_o    (u_stall),
        .result_o       (u_res),
        .result_valid_o (u_rv)
    );

    typedef struct {
        logic [2:0]  fun;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          stall;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic vec_t mk(input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] e,
                                input int s);
        vec_t v;
        v.fun = f; v.a = a; v.b = b; v.exp = e; v.stall = s;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one op, count stall_req cycles, then check the DONE cycle.
    task automatic issue(input bit sel, input logic [2:0] fun,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_stall,
                         input string name);
        int          cnt;
        logic [31:0] want;
        @(negedge clk);
        d_fun = fun; rs1 = a; rs2 = b;
        if (sel) u_valid = 1'b1;
        else     d_valid = 1'b1;
        sb_q.push_back(exp);
        cnt = 0;
        while (cnt < 200) begin
            #1;
            if (!(sel ? u_stall : m_stall)) break;
            cnt++;
            @(negedge clk);
            d_valid = 1'b0;
            u_valid = 1'b0;
        end
        d_valid = 1'b0;
        u_valid = 1'b0;
        chk({name, " stall"}, 32'(cnt), 32'(exp_stall));
        chk({name, " valid"}, {31'd0, sel ? u_rv : m_rv}, 32'd1);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            want = sb_q.pop_front();
            chk({name, " result"}, sel ? u_res : m_res, want);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nv;
        logic [31:0] held;

        rst = 1'b1; d_valid = 1'b0; u_valid = 1'b0;
        d_fun = 3'd0; rs1 = '0; rs2 = '0;
        x_stall = 1'b0; x_kill = 1'b0;

        vecs.push_back(mk(FUNC_MUL,    32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33));
        vecs.push_back(mk(FUNC_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33));
        vecs.push_back(mk(FUNC_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33));
        vecs.push_back(mk(FUNC_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33));
        vecs.push_back(mk(FUNC_MUL,    32'h12345678, 32'h10,       32'h23456780, 33));
        vecs.push_back(mk(FUNC_MULH,   32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 33));
        vecs.push_back(mk(FUNC_DIV,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 33));
        vecs.push_back(mk(FUNC_REM,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 33));
        vecs.push_back(mk(FUNC_DIVU,   32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 33));
        vecs.push_back(mk(FUNC_REMU,   32'hFFFFFFFF, 32'h10,       32'h0000000F, 33));
        vecs.push_back(mk(FUNC_DIV,    32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33));
        vecs.push_back(mk(FUNC_REM,    32'h7,        32'hFFFFFFFE, 32'h00000001, 33));
        vecs.push_back(mk(FUNC_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33));
        vecs.push_back(mk(FUNC_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33));
        vecs.push_back(mk(FUNC_DIV,    32'h5,        32'h0,        32'hFFFFFFFF, 1));
        vecs.push_back(mk(FUNC_REM,    32'h5,        32'h0,        32'h00000005, 1));
        vecs.push_back(mk(FUNC_DIVU,   32'h5,        32'h0,        32'hFFFFFFFF, 1));
        vecs.push_back(mk(FUNC_REMU,   32'h1234,     32'h0,        32'h00001234, 1));
        vecs.push_back(mk(FUNC_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1));
        vecs.push_back(mk(FUNC_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1));

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset result", m_res, 32'h0);
        chk("reset valid", {31'd0, m_rv}, 32'd0);
        chk("reset stall", {31'd0, m_stall}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            issue(1'b0, vecs[i].fun, vecs[i].a, vecs[i].b,
                  vecs[i].exp, vecs[i].stall, $sformatf("vec%0d", i));
        end

        // Kill a DIV at c10.
        @(negedge clk);
        d_fun = FUNC_DIV; rs1 = 32'd100; rs2 = 32'd7; d_valid = 1'b1;
        @(negedge clk);
        d_valid = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        chk("kill busy stall", {31'd0, m_stall}, 32'd1);
        x_kill = 1'b1;
        #1;
        chk("kill c10 stall", {31'd0, m_stall}, 32'd0);
        @(negedge clk);
        x_kill = 1'b0;
        #1;
        chk("kill c11 stall", {31'd0, m_stall}, 32'd0);
        chk("kill c11 valid", {31'd0, m_rv}, 32'd0);
        nv = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (m_rv || m_stall) nv++;
        end
        chk("kill no result", 32'(nv), 32'd0);
        issue(1'b0, FUNC_MUL, 32'd1000, 32'd3, 32'd3000, 33, "post kill mul");

        // Reset mid-BUSY.
        @(negedge clk);
        d_fun = FUNC_MULHU; rs1 = 32'hFFFFFFFF; rs2 = 32'h3; d_valid = 1'b1;
        @(negedge clk);
        d_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst busy result", m_res, 32'h0);
        chk("rst busy valid", {31'd0, m_rv}, 32'd0);
        chk("rst busy stall", {31'd0, m_stall}, 32'd0);
        nv = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (m_rv || m_stall) nv++;
        end
        chk("rst stays idle", 32'(nv), 32'd0);
        issue(1'b0, FUNC_REMU, 32'd1000, 32'd7, 32'd6, 33, "post rst remu");

        // Downstream stall holds DONE for four cycles.
        issue(1'b0, FUNC_DIVU, 32'd1000, 32'd3, 32'd333, 33, "hold divu");
        held = m_res;
        x_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 2) x_stall = 1'b0;
            #1;
            chk($sformatf("hold valid %0d", k), {31'd0, m_rv}, 32'd1);
            chk($sformatf("hold result %0d", k), m_res, 32'd333);
            chk($sformatf("hold stall %0d", k), {31'd0, m_stall}, 32'd0);
        end
        @(negedge clk);
        #1;
        chk("hold released", {31'd0, m_rv}, 32'd0);
        chk("hold result kept", m_res, held);

        // Back-to-back right after DONE exits.
        issue(1'b0, FUNC_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 33, "b2b mul a");
        issue(1'b0, FUNC_DIV, 32'h80000000, 32'h0, 32'hFFFFFFFF, 1, "b2b div0");

        // Four multiplier bits per cycle.
        issue(1'b1, FUNC_MUL, 32'h12345678, 32'h10, 32'h23456780, 9, "u4 mul");
        issue(1'b1, FUNC_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 9, "u4 mulhu");
        issue(1'b1, FUNC_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 9, "u4 mulh");
        issue(1'b1, FUNC_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 33, "u4 div");

        chk("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
